// File: rtl/trig_ctrl_pkg.sv
// Shared constants and types for the trigger generator control block.
package trig_ctrl_pkg;

  // Register map
  localparam logic [1:0] ADDR_MASK_LO = 2'd0;
  localparam logic [1:0] ADDR_MASK_HI = 2'd1;
  localparam logic [1:0] ADDR_OFFSET  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  // Control register bit indices
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_GENRST = 3;

  // Beam mask split across the DSP B (low) and A (high) input registers
  localparam int MASK_B_BITS = 18;
  localparam int MASK_A_BITS = 30;
  localparam int MASK_BITS   = MASK_B_BITS + MASK_A_BITS;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_QUIET = 2'd1,
    ST_COMMIT     = 2'd2,
    ST_RESET      = 2'd3
  } state_t;

  // Bits [MASK_BITS-1:nbeams] set: beams that do not exist stay masked.
  function automatic logic [MASK_BITS-1:0] forced_mask(input int nbeams);
    logic [MASK_BITS:0] lo;
    lo = ({{MASK_BITS{1'b0}}, 1'b1} << nbeams) - {{MASK_BITS{1'b0}}, 1'b1};
    return ~lo[MASK_BITS-1:0];
  endfunction

endpackage

// File: rtl/trig_gen_ctrl.sv
// Trigger generator control: stages the beam mask into the DSP A/B
// registers, commits it once trigger activity has been quiet, issues
// run start/stop pulses and a stretched generator reset.
module trig_gen_ctrl
  import trig_ctrl_pkg::*;
#(
  parameter int NBEAMS         = 48,
  parameter int QUIET_CYCLES   = 8,
  parameter int RST_CYCLES     = 16,
  parameter int COMMIT_TIMEOUT = 1023
) (
  input  logic                 ifclk,
  input  logic                 ifclk_rstn,
  input  logic                 reg_wr_i,
  input  logic [1:0]           reg_addr_i,
  input  logic [31:0]          reg_dat_i,
  input  logic                 trig_active_i,
  output logic [MASK_BITS-1:0] mask_o,
  output logic [1:0]           mask_wr_o,
  output logic                 mask_update_o,
  output logic [11:0]          offset_o,
  output logic                 runrst_o,
  output logic                 runstop_o,
  output logic                 gen_rst_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [7:0]           commit_cnt_o
);

  localparam logic [MASK_BITS-1:0] FORCE = forced_mask(NBEAMS);

  localparam int QW  = $clog2(QUIET_CYCLES + 1);
  localparam int TW  = $clog2(COMMIT_TIMEOUT + 1);
  localparam int RW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

  localparam logic [QW-1:0] QMAX = QW'(QUIET_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(COMMIT_TIMEOUT);
  localparam logic [RW-1:0] RMAX = RW'(RST_CYCLES - 1);

  // Write decode
  logic wr_lo, wr_hi, wr_off, wr_ctrl;
  logic c_commit, c_start, c_stop, c_genrst;

  assign wr_lo    = reg_wr_i && (reg_addr_i == ADDR_MASK_LO);
  assign wr_hi    = reg_wr_i && (reg_addr_i == ADDR_MASK_HI);
  assign wr_off   = reg_wr_i && (reg_addr_i == ADDR_OFFSET);
  assign wr_ctrl  = reg_wr_i && (reg_addr_i == ADDR_CTRL);
  assign c_commit = wr_ctrl && reg_dat_i[CTRL_COMMIT];
  assign c_start  = wr_ctrl && reg_dat_i[CTRL_START];
  assign c_stop   = wr_ctrl && reg_dat_i[CTRL_STOP];
  assign c_genrst = wr_ctrl && reg_dat_i[CTRL_GENRST];

  logic unused_dat;
  assign unused_dat = ^reg_dat_i[31:MASK_A_BITS];

  // Mask staging: data and its load strobe register on the same edge so the
  // DSP captures a settled value on the following edge.
  logic [MASK_BITS-1:0] mask_q;
  logic [1:0]           mask_wr_q;

  // Mask halves and their per-half load strobes
  always_ff @(posedge ifclk or negedge ifclk_rstn) begin
    if (!ifclk_rstn) begin
      mask_q    <= '1;
      mask_wr_q <= '0;
    end else begin
      mask_wr_q <= {wr_hi, wr_lo};
      if (wr_lo)
        mask_q[MASK_B_BITS-1:0] <= reg_dat_i[MASK_B_BITS-1:0] | FORCE[MASK_B_BITS-1:0];
      if (wr_hi)
        mask_q[MASK_BITS-1:MASK_B_BITS] <= reg_dat_i[MASK_A_BITS-1:0] | FORCE[MASK_BITS-1:MASK_B_BITS];
    end
  end

  // Address offset register
  logic [11:0] offset_q;
  always_ff @(posedge ifclk or negedge ifclk_rstn) begin
    if (!ifclk_rstn) offset_q <= '0;
    else if (wr_off) offset_q <= reg_dat_i[11:0];
  end

  // Run start/stop pulses; stop wins when both are requested
  logic runrst_q, runstop_q;
  always_ff @(posedge ifclk or negedge ifclk_rstn) begin
    if (!ifclk_rstn) begin
      runrst_q  <= 1'b0;
      runstop_q <= 1'b0;
    end else begin
      runrst_q  <= c_start && !c_stop;
      runstop_q <= c_stop;
    end
  end

  // Commit / reset sequencer
  state_t        state_q, state_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pend_q, pend_d;
  logic          upd_q, upd_d;
  logic          ovr_q, ovr_d;
  logic          grst_q, grst_d;
  logic          busy_q;
  logic [7:0]    cnt_q, cnt_d;

  // Next-state logic; a generator reset request overrides everything else
  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    tmo_d   = tmo_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_q;
    upd_d   = 1'b0;
    ovr_d   = ovr_q;
    grst_d  = grst_q;
    cnt_d   = cnt_q;
    if (c_genrst) begin
      // A commit in flight (or arriving with the reset) resumes afterwards.
      state_d = ST_RESET;
      rcnt_d  = '0;
      grst_d  = 1'b1;
      pend_d  = pend_q || c_commit || (state_q == ST_WAIT_QUIET);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (c_commit) begin
            state_d = ST_WAIT_QUIET;
            quiet_d = '0;
            tmo_d   = '0;
          end
        end
        ST_WAIT_QUIET: begin
          if (quiet_q == QMAX) begin
            state_d = ST_COMMIT;
            upd_d   = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end else if (tmo_q == TMAX) begin
            state_d = ST_COMMIT;
            upd_d   = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            ovr_d   = 1'b1;
          end else begin
            tmo_d   = tmo_q + 1'b1;
            quiet_d = trig_active_i ? '0 : quiet_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          state_d = ST_IDLE;
        end
        ST_RESET: begin
          if (rcnt_q == RMAX) begin
            grst_d  = 1'b0;
            state_d = (pend_q || c_commit) ? ST_WAIT_QUIET : ST_IDLE;
            pend_d  = 1'b0;
            quiet_d = '0;
            tmo_d   = '0;
            rcnt_d  = '0;
          end else begin
            rcnt_d  = rcnt_q + 1'b1;
            pend_d  = pend_q || c_commit;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state registers; pulses and busy are registered with the state
  always_ff @(posedge ifclk or negedge ifclk_rstn) begin
    if (!ifclk_rstn) begin
      state_q <= ST_IDLE;
      quiet_q <= '0;
      tmo_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      ovr_q   <= 1'b0;
      grst_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      tmo_q   <= tmo_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      ovr_q   <= ovr_d;
      grst_q  <= grst_d;
      busy_q  <= (state_d != ST_IDLE);
      cnt_q   <= cnt_d;
    end
  end

  assign mask_o        = mask_q;
  assign mask_wr_o     = mask_wr_q;
  assign mask_update_o = upd_q;
  assign offset_o      = offset_q;
  assign runrst_o      = runrst_q;
  assign runstop_o     = runstop_q;
  assign gen_rst_o     = grst_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;
  assign commit_cnt_o  = cnt_q;

endmodule

// File: tb/tb_trig_gen_ctrl.sv
// Self-checking bench for trig_gen_ctrl: directed steps plus randomized
// activity patterns checked against a window-based commit model.
module tb_trig_gen_ctrl;
  import trig_ctrl_pkg::*;

  localparam int QC  = 8;
  localparam int RC  = 16;
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        reg_wr = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] dat = '0;
  logic        trig = 1'b0;

  logic [47:0] mask, mask2;
  logic [1:0]  mwr, mwr2;
  logic        upd, upd2, rr, rr2, rs, rs2, grst, grst2, busy, busy2, ovr, ovr2;
  logic [11:0] off, off2;
  logic [7:0]  cnt, cnt2;

  trig_gen_ctrl u_dut (
    .ifclk(clk), .ifclk_rstn(rstn), .reg_wr_i(reg_wr), .reg_addr_i(addr),
    .reg_dat_i(dat), .trig_active_i(trig), .mask_o(mask), .mask_wr_o(mwr),
    .mask_update_o(upd), .offset_o(off), .runrst_o(rr), .runstop_o(rs),
    .gen_rst_o(grst), .busy_o(busy), .overrun_o(ovr), .commit_cnt_o(cnt)
  );

  trig_gen_ctrl #(.NBEAMS(2)) u_nb2 (
    .ifclk(clk), .ifclk_rstn(rstn), .reg_wr_i(reg_wr), .reg_addr_i(addr),
    .reg_dat_i(dat), .trig_active_i(trig), .mask_o(mask2), .mask_wr_o(mwr2),
    .mask_update_o(upd2), .offset_o(off2), .runrst_o(rr2), .runstop_o(rs2),
    .gen_rst_o(grst2), .busy_o(busy2), .overrun_o(ovr2), .commit_cnt_o(cnt2)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [47:0] mdl_mask = '1;
  int          mdl_cnt  = 0;
  bit          mdl_ovr  = 1'b0;
  bit          act_e [0:1099];   // trig_active value present at edge e after commit

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One register write, sampled on the next rising edge; returns in the
  // cycle following that edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_wr = 1'b1; addr = a; dat = d;
    @(negedge clk);
    reg_wr = 1'b0; dat = '0;
    if (a == ADDR_MASK_LO) mdl_mask[17:0]  = d[17:0];
    if (a == ADDR_MASK_HI) mdl_mask[47:18] = d[29:0];
  endtask

  // Commit fires at the first edge preceded by QC consecutive idle edges
  // (counting from edge 1 after acceptance), else when the timeout expires.
  function automatic void model_commit(output int e, output bit ov);
    for (int c = QC + 1; c <= TMO + 1; c++) begin
      bit q = 1'b1;
      for (int j = c - QC; j < c; j++) if (act_e[j]) q = 1'b0;
      if (q) begin e = c; ov = 1'b0; return; end
    end
    e = TMO + 1; ov = 1'b1;
  endfunction

  task automatic commit_and_check(input string tag);
    int e; bit ov; int first; int np;
    first = -1; np = 0;
    model_commit(e, ov);
    wr(ADDR_CTRL, 32'h1);
    chk({tag, " busy"}, busy, 1);
    for (int k = 0; k <= e + 3; k++) begin
      if (upd) begin np++; if (first < 0) first = k; end
      trig = act_e[k + 1];
      @(negedge clk);
    end
    trig = 1'b0;
    mdl_cnt = (mdl_cnt + 1) % 256;
    mdl_ovr = mdl_ovr | ov;
    chk({tag, " pulse_at"}, first, e);
    chk({tag, " pulses"}, np, 1);
    chk({tag, " cnt"}, cnt, mdl_cnt);
    chk({tag, " ovr"}, ovr, mdl_ovr);
    chk({tag, " idle"}, busy, 0);
  endtask

  // Generator reset, optionally landing 3 edges after a commit request.
  task automatic reset_check(input string tag, input bit commit_first);
    int ng; int first; int np;
    ng = 0; first = -1; np = 0;
    if (commit_first) begin
      wr(ADDR_CTRL, 32'h1);
      @(negedge clk);
      @(negedge clk);
      wr(ADDR_CTRL, 32'h8);
    end else begin
      wr(ADDR_CTRL, 32'h9);
    end
    for (int k = 0; k <= RC + QC + 6; k++) begin
      if (grst) ng++;
      if (upd) begin np++; if (first < 0) first = k; end
      @(negedge clk);
    end
    mdl_cnt = (mdl_cnt + 1) % 256;
    chk({tag, " grst_len"}, ng, RC);
    chk({tag, " pulse_at"}, first, RC + QC + 1);
    chk({tag, " pulses"}, np, 1);
    chk({tag, " cnt"}, cnt, mdl_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r0, r1;
    int np;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst mask", mask, 48'hFFFF_FFFF_FFFF);
    chk("rst outs", {mwr, upd, rr, rs, grst, busy, ovr}, 0);
    chk("rst offset", off, 0);
    chk("rst cnt", cnt, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Mask half writes
    wr(ADDR_MASK_LO, 32'h3FFFF);
    chk("mwr lo", mwr, 2'b01);
    wr(ADDR_MASK_HI, 32'h0);
    chk("mwr hi", mwr, 2'b10);
    chk("mask split", mask, 48'h0000_0003_FFFF);
    @(negedge clk);
    chk("mwr clear", mwr, 2'b00);

    // Unused beams stay masked
    wr(ADDR_MASK_LO, 32'h0);
    chk("nb2 mask", mask2, 48'hFFFF_FFFF_FFFC);
    chk("nb48 mask", mask, mdl_mask);

    // Commit latency with no activity
    for (int i = 0; i < 1100; i++) act_e[i] = 1'b0;
    commit_and_check("quiet");

    // Random masks and sparse activity
    for (int it = 0; it < 6; it++) begin
      r0 = $urandom; r1 = $urandom;
      wr(ADDR_MASK_LO, r0);
      wr(ADDR_MASK_HI, r1);
      chk("rnd mask", mask, mdl_mask);
      chk("rnd mask nb2", mask2, mdl_mask | 48'hFFFF_FFFF_FFFC);
      for (int i = 0; i < 1100; i++) act_e[i] = ($urandom_range(0, 5) == 0);
      commit_and_check("rnd");
    end

    // Generator reset interrupting a commit, and together with a commit
    reset_check("rst_mid", 1'b1);
    reset_check("rst_both", 1'b0);

    // Offset and run control
    wr(ADDR_OFFSET, 32'h123);
    wr(ADDR_CTRL, 32'h6);
    chk("both stop", rs, 1);
    chk("both start", rr, 0);
    @(negedge clk);
    chk("stop clear", rs, 0);
    wr(ADDR_CTRL, 32'h2);
    chk("start", {rr, rs}, 2'b10);
    chk("start offset", off, 12'h123);
    chk("run no busy", busy, 0);

    // Activity every 5 cycles forces the timeout
    for (int i = 0; i < 1100; i++) act_e[i] = (i % 5 == 0);
    commit_and_check("timeout");

    // Asynchronous reset mid-wait
    wr(ADDR_CTRL, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    mdl_cnt = 0; mdl_ovr = 1'b0; mdl_mask = '1;
    chk("arst busy", busy, 0);
    chk("arst ovr", ovr, mdl_ovr);
    chk("arst cnt", cnt, mdl_cnt);
    chk("arst mask", mask, mdl_mask);
    @(negedge clk);
    rstn = 1'b1;
    np = 0;
    for (int k = 0; k < QC + 8; k++) begin
      if (upd) np++;
      @(negedge clk);
    end
    chk("arst no pulse", np, 0);
    chk("arst idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
